// File: rtl/CorePack.sv
// Shared core types for the MEM-stage data-memory access controller.
// Holds the memory-op encoding, byte-mask/address types, the controller
// FSM states and helpers that decode an op into size and signedness.
package CorePack;

  typedef logic [63:0] addr_t;
  typedef logic [7:0]  mask_t;

  typedef enum logic [2:0] {
    MEM_NO,
    MEM_B,
    MEM_H,
    MEM_W,
    MEM_D,
    MEM_UB,
    MEM_UH,
    MEM_UW
  } mem_op_enum;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    RESP
  } dmem_ctrl_state_e;

  // Number of bytes touched by an op; zero for MEM_NO.
  function automatic logic [3:0] mem_op_size(input mem_op_enum op);
    logic [3:0] size;
    case (op)
      MEM_B, MEM_UB: size = 4'd1;
      MEM_H, MEM_UH: size = 4'd2;
      MEM_W, MEM_UW: size = 4'd4;
      MEM_D:         size = 4'd8;
      default:       size = 4'd0;
    endcase
    return size;
  endfunction

  // True for the sign-extending load variants.
  function automatic logic mem_op_signed(input mem_op_enum op);
    return (op == MEM_B) || (op == MEM_H) || (op == MEM_W);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Truncates right-justified load data to the access size and applies
// sign or zero extension according to the op.
module load_extend
  import CorePack::*;
(
  input  mem_op_enum  op,
  input  logic [63:0] raw,
  output logic [63:0] ext
);

  logic sgn;

  // Pick the size slice and fill the upper bits with the extension bit.
  always_comb begin
    ext = '0;
    sgn = mem_op_signed(op);
    case (mem_op_size(op))
      4'd1:    ext = {{56{sgn & raw[7]}},  raw[7:0]};
      4'd2:    ext = {{48{sgn & raw[15]}}, raw[15:0]};
      4'd4:    ext = {{32{sgn & raw[31]}}, raw[31:0]};
      4'd8:    ext = raw;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller. Accepts one load/store at a
// time from the core, issues one or two aligned 64-bit beats to memory
// (two when the access crosses an 8-byte boundary), merges and extends
// load data, and returns a single response pulse.
// Optional build macro DMEM_MISALIGN_TRAP_EN: boundary-crossing accesses
// are not issued and instead complete at once with resp_fault = 1.
module dmem_access_ctrl
  import CorePack::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  mem_op_enum        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output mask_t             dmem_wmask,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_rdata
);

  dmem_ctrl_state_e state, state_next;

  logic              accept;
  logic [3:0]        size_in;
  logic [2:0]        off_in;
  logic              split_in;

  logic              we_q;
  mem_op_enum        op_q;
  logic [ADDR_W-1:3] base_q;
  logic [ADDR_W-1:3] base_next;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        off_q;
  logic              split_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              fault;

  logic [15:0]       lane_bytes;
  logic [DATA_W-1:0] wdata_beat0;
  logic [DATA_W-1:0] wdata_beat1;
  logic [63:0]       load_raw;
  logic [63:0]       load_ext;

  assign accept   = req_valid && req_ready;
  assign size_in  = mem_op_size(req_op);
  assign off_in   = req_addr[2:0];
  assign split_in = ({2'b00, off_in} + {1'b0, size_in}) > 5'd8;

  // Byte lanes of the whole access across both beats, and each beat's
  // lane-shifted store data. The second beat only exists when off != 0.
  assign lane_bytes  = ((16'd1 << mem_op_size(op_q)) - 16'd1) << off_q;
  assign wdata_beat0 = wdata_q << {off_q, 3'b000};
  assign wdata_beat1 = wdata_q >> (7'd64 - {1'b0, off_q, 3'b000});
  assign base_next   = base_q + {{(ADDR_W-4){1'b0}}, 1'b1};

  // Both beats concatenated and shifted so the addressed byte sits at bit 0.
  assign load_raw = 64'({rdata1_q, rdata0_q} >> {off_q, 3'b000});

  load_extend u_load_extend (
    .op  (op_q),
    .raw (load_raw),
    .ext (load_ext)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic fault_q;

  // Remember that the captured access crosses a boundary and will trap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= split_in;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; memory outputs are only non-zero while
  // a beat is being offered so they read as zero whenever idle.
  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_fault     = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_we        = 1'b0;
    dmem_addr      = '0;
    dmem_wdata     = '0;
    dmem_wmask     = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_op == MEM_NO) begin
            state_next = RESP;
`ifdef DMEM_MISALIGN_TRAP_EN
          end else if (split_in) begin
            state_next = RESP;
`endif
          end else begin
            state_next = REQ0;
          end
        end
      end
      REQ0: begin
        dmem_req_valid = 1'b1;
        dmem_we        = we_q;
        dmem_addr      = {base_q, 3'b000};
        dmem_wdata     = wdata_beat0;
        dmem_wmask     = we_q ? lane_bytes[7:0] : 8'h00;
        if (dmem_req_ready) begin
          state_next = WAIT0;
        end
      end
      WAIT0: begin
        if (dmem_resp_valid) begin
          state_next = split_q ? REQ1 : RESP;
        end
      end
      REQ1: begin
        dmem_req_valid = 1'b1;
        dmem_we        = we_q;
        dmem_addr      = {base_next, 3'b000};
        dmem_wdata     = wdata_beat1;
        dmem_wmask     = we_q ? lane_bytes[15:8] : 8'h00;
        if (dmem_req_ready) begin
          state_next = WAIT1;
        end
      end
      WAIT1: begin
        if (dmem_resp_valid) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault;
        resp_rdata = (we_q || fault) ? '0 : load_ext;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request on accept and latch each beat's read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q     <= 1'b0;
      op_q     <= MEM_NO;
      base_q   <= '0;
      wdata_q  <= '0;
      off_q    <= 3'd0;
      split_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        op_q     <= req_op;
        base_q   <= req_addr[ADDR_W-1:3];
        wdata_q  <= req_wdata;
        off_q    <= off_in;
        split_q  <= split_in;
        rdata1_q <= '0;
      end
      if ((state == WAIT0) && dmem_resp_valid) begin
        rdata0_q <= dmem_rdata;
      end
      if ((state == WAIT1) && dmem_resp_valid) begin
        rdata1_q <= dmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl. The bench plays the
// memory side by hand, one cycle at a time, and compares against
// hand-computed beat addresses, masks, data and responses.
module tb_dmem_access_ctrl;
  import CorePack::*;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  mem_op_enum  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  mask_t       dmem_wmask;
  logic        dmem_resp_valid;
  logic [63:0] dmem_rdata;

  int tests;
  int failures;

  dmem_access_ctrl #(
    .ADDR_W (64),
    .DATA_W (64)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wmask      (dmem_wmask),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_rdata      (dmem_rdata)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic we, input mem_op_enum op,
                                input logic [63:0] addr, input logic [63:0] wdata);
    req_valid = valid;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // Checks the beat currently offered, accepts it, then returns read data.
  // Entered in a REQ cycle, leaves in the cycle after the WAIT cycle.
  task automatic mem_beat(input string tag, input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                          input logic [63:0] exp_wdata, input logic exp_we, input logic [63:0] rdata);
    check_output({tag, "_valid"}, {63'd0, dmem_req_valid}, 64'd1);
    check_output({tag, "_addr"},  dmem_addr, exp_addr);
    check_output({tag, "_mask"},  {56'd0, dmem_wmask}, {56'd0, exp_mask});
    check_output({tag, "_wdata"}, dmem_wdata, exp_wdata);
    check_output({tag, "_we"},    {63'd0, dmem_we}, {63'd0, exp_we});
    check_output({tag, "_noresp"}, {63'd0, resp_valid}, 64'd0);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready  = 1'b0;
    check_output({tag, "_wait_idle"}, {63'd0, dmem_req_valid}, 64'd0);
    dmem_resp_valid = 1'b1;
    dmem_rdata      = rdata;
    tick();
    dmem_resp_valid = 1'b0;
    dmem_rdata      = 64'd0;
  endtask

  // Checks the response pulse and its return to idle.
  task automatic finish_resp(input string tag, input logic [63:0] exp_rdata);
    check_output({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
    check_output({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
    check_output({tag, "_resp_fault"}, {63'd0, resp_fault}, 64'd0);
    check_output({tag, "_resp_ready"}, {63'd0, req_ready}, 64'd0);
    tick();
    check_output({tag, "_resp_pulse"}, {63'd0, resp_valid}, 64'd0);
    check_output({tag, "_idle_ready"}, {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    tests           = 0;
    failures        = 0;
    rstn            = 1'b0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_rdata      = 64'd0;
    apply_stimulus(1'b0, 1'b0, MEM_NO, 64'd0, 64'd0);
    tick();
    tick();

    // Reset state.
    check_output("rst_ready",      {63'd0, req_ready}, 64'd1);
    check_output("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check_output("rst_dmem_valid", {63'd0, dmem_req_valid}, 64'd0);
    check_output("rst_dmem_addr",  dmem_addr, 64'd0);
    check_output("rst_dmem_mask",  {56'd0, dmem_wmask}, 64'd0);
    rstn = 1'b1;
    tick();

    // Aligned signed word load from 0x1004.
    apply_stimulus(1'b1, 1'b0, MEM_W, 64'h1004, 64'd0);
    check_output("ldw_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    mem_beat("ldw", 64'h1000, 8'h00, 64'd0, 1'b0, 64'h8000_0001_DEAD_BEEF);
    finish_resp("ldw", 64'hFFFF_FFFF_8000_0001);

    // Signed byte and unsigned half from the same lanes.
    apply_stimulus(1'b1, 1'b0, MEM_B, 64'h6003, 64'd0);
    tick();
    req_valid = 1'b0;
    mem_beat("ldb", 64'h6000, 8'h00, 64'd0, 1'b0, 64'h0000_0000_9C80_0000);
    finish_resp("ldb", 64'hFFFF_FFFF_FFFF_FF9C);

    apply_stimulus(1'b1, 1'b0, MEM_UH, 64'h6002, 64'd0);
    tick();
    req_valid = 1'b0;
    mem_beat("lduh", 64'h6000, 8'h00, 64'd0, 1'b0, 64'h0000_0000_9C80_0000);
    finish_resp("lduh", 64'h0000_0000_0000_9C80);

    // Byte store: shifted data, single-lane mask.
    apply_stimulus(1'b1, 1'b1, MEM_B, 64'h2005, 64'h0000_0000_FFFF_FF5A);
    tick();
    req_valid = 1'b0;
    mem_beat("stb", 64'h2000, 8'h20, 64'hFFFF_5A00_0000_0000, 1'b1, 64'd0);
    finish_resp("stb", 64'd0);

`ifndef DMEM_MISALIGN_TRAP_EN
    // Split half store across 0x2007/0x2008.
    apply_stimulus(1'b1, 1'b1, MEM_H, 64'h2007, 64'h0000_0000_0000_BEEF);
    tick();
    req_valid = 1'b0;
    mem_beat("sth0", 64'h2000, 8'h80, 64'hEF00_0000_0000_0000, 1'b1, 64'd0);
    mem_beat("sth1", 64'h2008, 8'h01, 64'h0000_0000_0000_00BE, 1'b1, 64'd0);
    finish_resp("sth", 64'd0);

    // Split unsigned word load merging two beats.
    apply_stimulus(1'b1, 1'b0, MEM_UW, 64'h3006, 64'd0);
    tick();
    req_valid = 1'b0;
    mem_beat("lduw0", 64'h3000, 8'h00, 64'd0, 1'b0, 64'h1122_5555_5555_5555);
    mem_beat("lduw1", 64'h3008, 8'h00, 64'd0, 1'b0, 64'hAAAA_AAAA_AAAA_3344);
    finish_resp("lduw", 64'h0000_0000_3344_1122);

    // Split doubleword at the top of memory wraps the second beat to 0.
    apply_stimulus(1'b1, 1'b0, MEM_D, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0);
    tick();
    req_valid = 1'b0;
    mem_beat("ldwrap0", 64'hFFFF_FFFF_FFFF_FFF8, 8'h00, 64'd0, 1'b0, 64'h1122_3344_5566_7788);
    mem_beat("ldwrap1", 64'h0000_0000_0000_0000, 8'h00, 64'd0, 1'b0, 64'h99AA_BBCC_DDEE_FFA5);
    finish_resp("ldwrap", 64'hA511_2233_4455_6677);
`endif

    // Doubleword store with memory stalling for three cycles; a stray
    // memory response during the stall must not advance the FSM.
    apply_stimulus(1'b1, 1'b1, MEM_D, 64'h4000, 64'h0123_4567_89AB_CDEF);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output("std_stall_valid", {63'd0, dmem_req_valid}, 64'd1);
      check_output("std_stall_addr",  dmem_addr, 64'h4000);
      check_output("std_stall_wdata", dmem_wdata, 64'h0123_4567_89AB_CDEF);
      check_output("std_stall_mask",  {56'd0, dmem_wmask}, 64'h0000_0000_0000_00FF);
      dmem_resp_valid = (i == 1);
      tick();
    end
    dmem_resp_valid = 1'b0;
    mem_beat("std", 64'h4000, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, 64'd0);
    finish_resp("std", 64'd0);

    // MEM_NO held back-to-back: no memory traffic, no accept during RESP.
    apply_stimulus(1'b1, 1'b0, MEM_NO, 64'h1234, 64'd0);
    tick();
    check_output("no_resp_valid", {63'd0, resp_valid}, 64'd1);
    check_output("no_resp_rdata", resp_rdata, 64'd0);
    check_output("no_resp_ready", {63'd0, req_ready}, 64'd0);
    check_output("no_dmem_valid", {63'd0, dmem_req_valid}, 64'd0);
    tick();
    check_output("no_gap_valid",  {63'd0, resp_valid}, 64'd0);
    check_output("no_gap_ready",  {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    check_output("no_second_resp", {63'd0, resp_valid}, 64'd1);
    tick();
    check_output("no_second_done", {63'd0, resp_valid}, 64'd0);

`ifndef DMEM_MISALIGN_TRAP_EN
    // Reset during WAIT1 abandons the access without a response.
    apply_stimulus(1'b1, 1'b0, MEM_W, 64'h7006, 64'd0);
    tick();
    req_valid = 1'b0;
    mem_beat("rstw0", 64'h7000, 8'h00, 64'd0, 1'b0, 64'h5555_5555_5555_5555);
    check_output("rstw_req1_valid", {63'd0, dmem_req_valid}, 64'd1);
    check_output("rstw_req1_addr",  dmem_addr, 64'h7008);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check_output("rstw_wait1", {63'd0, dmem_req_valid}, 64'd0);
    rstn = 1'b0;
    #1;
    check_output("rstw_ready",      {63'd0, req_ready}, 64'd1);
    check_output("rstw_resp_valid", {63'd0, resp_valid}, 64'd0);
    check_output("rstw_dmem_valid", {63'd0, dmem_req_valid}, 64'd0);
    tick();
    rstn            = 1'b1;
    dmem_resp_valid = 1'b1;
    dmem_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dmem_resp_valid = 1'b0;
    check_output("rstw_late_resp",  {63'd0, resp_valid}, 64'd0);
    check_output("rstw_late_ready", {63'd0, req_ready}, 64'd1);
    check_output("rstw_late_dmem",  {63'd0, dmem_req_valid}, 64'd0);
    tick();
    check_output("rstw_still_quiet", {63'd0, resp_valid}, 64'd0);
`else
    // Misaligned doubleword traps straight to a faulting response.
    apply_stimulus(1'b1, 1'b0, MEM_D, 64'h5001, 64'd0);
    tick();
    req_valid = 1'b0;
    check_output("trap_dmem_valid", {63'd0, dmem_req_valid}, 64'd0);
    check_output("trap_resp_valid", {63'd0, resp_valid}, 64'd1);
    check_output("trap_resp_fault", {63'd0, resp_fault}, 64'd1);
    check_output("trap_resp_rdata", resp_rdata, 64'd0);
    tick();
    check_output("trap_done_valid", {63'd0, resp_valid}, 64'd0);
    check_output("trap_done_fault", {63'd0, resp_fault}, 64'd0);
    check_output("trap_done_ready", {63'd0, req_ready}, 64'd1);
    check_output("trap_no_beat",    {63'd0, dmem_req_valid}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every MEM-stage load/store onto the 64-bit data-memory port over a valid/ready request channel and a response channel.
- Generates byte write masks and positions store data for each beat.
- Splits accesses that cross an 8-byte boundary into two aligned beats.
- Merges and sign/zero-extends load data, then returns a single response to the core.

Parameters:
- ADDR_W, 64, address width (matches CorePack::addr_t)
- DATA_W, 64, data width; must be 64 (8 byte lanes, matches CorePack::mask_t)

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_op  in  CorePack::mem_op_enum  access size/signedness
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores and MEM_NO
- resp_fault  out  1  misaligned fault (see Optional Feature)
- dmem_req_valid  out  1  beat request to memory
- dmem_req_ready  in  1  memory accepts beat
- dmem_we  out  1  beat is a write
- dmem_addr  out  ADDR_W  beat address, bits [2:0] = 0
- dmem_wdata  out  DATA_W  lane-shifted store data
- dmem_wmask  out  CorePack::mask_t  byte enables; 0 for loads
- dmem_resp_valid  in  1  beat done (read data valid or write ack)
- dmem_rdata  in  DATA_W  beat read data

Behaviour:
- Reset (async, rstn low):
  - state = IDLE, req_ready = 1, all other outputs 0, beat registers cleared.
  - Reset mid-transaction abandons it with no response.
- Size decoding:
  - size = 1 for B/UB, 2 for H/UH, 4 for W/UW, 8 for D, 0 for NO.
  - off = addr[2:0].
  - bytes = ((1 << size) − 1) << off, computed in 16 bits.
  - split = (off + size > 8).
- Request capture:
  - Accept when req_valid && req_ready.
  - Register we, op, addr, wdata, off and split.
  - MEM_NO goes to RESP directly; no dmem traffic.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE → REQ0 on accept.
  - REQ0: dmem_req_valid = 1, addr = {addr[63:3], 3'b0}, wmask = bytes[7:0] (0 if load), wdata = wdata << 8·off. All outputs are held stable until dmem_req_ready; → WAIT0.
  - WAIT0: on dmem_resp_valid, latch rdata0; → REQ1 if split, else RESP.
  - REQ1: addr = aligned addr + 8 (64-bit wrap at top of memory), wmask = bytes[15:8], wdata = wdata >> 8·(8−off). Same hold rule as REQ0; → WAIT1.
  - WAIT1: latch rdata1 on dmem_resp_valid → RESP.
  - RESP: resp_valid = 1 for exactly one cycle → IDLE.
- Load merge and extension:
  - raw = ({rdata1, rdata0} >> 8·off)[63:0].
  - Truncate raw to size; sign-extend for B/H/W, zero-extend for UB/UH/UW/D.
- Latency (zero-wait memory):
  - Aligned: accept at T, dmem request at T+1, response at T+2, resp_valid at T+3.
  - Split: resp_valid at T+5.
- Edge cases:
  - dmem_resp_valid outside WAIT0/WAIT1 is ignored.
  - dmem_req_ready is ignored outside REQ0/REQ1.
  - No new request is accepted in the same cycle as resp_valid; the next accept happens in IDLE.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a split access is not issued. The controller goes IDLE → RESP with resp_fault = 1, resp_rdata = 0 and no dmem beats.
- Undefined: split accesses take two beats as described above, and resp_fault is tied to 0.

Decomposition:
- CorePack additions: dmem_ctrl_state_e (six states), function mem_op_size(mem_op_enum) returning a 4-bit byte count, and function mem_op_signed(mem_op_enum).
- One natural sub-module: load_extend (combinational; op + raw 64-bit in, extended 64-bit out).

Test Plan:
- Load MEM_W from addr 0x1004, dmem_rdata = 0x8000_0001_xxxx_xxxx:
  - one beat, addr 0x1000, wmask 0.
  - resp_rdata = 0xFFFF_FFFF_8000_0001 at T+3.
- Store MEM_H, addr 0x2007, wdata 0xBEEF:
  - beat 0 at 0x2000, wmask 0x80, wdata[63:56] = 0xEF.
  - beat 1 at 0x2008, wmask 0x01, wdata[7:0] = 0xBE.
  - resp_valid at T+5.
- Load MEM_UW from addr 0x3006, rdata0[63:48] = 0x1122, rdata1[15:0] = 0x3344:
  - resp_rdata = 0x0000_0000_3344_1122.
- Store MEM_D to 0x4000 with dmem_req_ready low for 3 cycles:
  - dmem_addr, wdata and wmask = 0xFF stay stable throughout.
  - resp_valid is delayed by 3 cycles.
- rstn asserted during WAIT1:
  - all outputs 0 immediately, req_ready = 1.
  - no resp_valid; a late dmem_resp_valid is ignored.
- DMEM_MISALIGN_TRAP_EN defined, load MEM_D at 0x5001:
  - no dmem_req_valid.
  - resp_valid with resp_fault = 1 and resp_rdata = 0 at T+1.
